// File: rtl/alu_seq_control.sv
// alu_seq_control: registered ALU control decoder that also sequences multi-cycle MULT/DIV.
// Define ALU_SEQ_MD_EARLY_DONE_EN to add the md_early input that ends a MULT/DIV run early.
module alu_seq_control #(
    parameter int CTRL_W    = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CTRL_W-1:0] controlType,
    input  logic              flush,
`ifdef ALU_SEQ_MD_EARLY_DONE_EN
    input  logic              md_early,
`endif
    output logic [1:0]        condType,
    output logic              divOp,
    output logic              multOp,
    output logic [2:0]        ALUOp,
    output logic              orOp,
    output logic              overflowOp,
    output logic [2:0]        SrcOut,
    output logic [1:0]        StoreMD,
    output logic              ALUOutSave,
    output logic              busy,
    output logic              op_done,
    output logic              illegal_op
);
    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MD_RUN, MD_WB} state_t;

    typedef struct packed {
        logic [1:0] cond;
        logic       div;
        logic       mult;
        logic [2:0] alu;
        logic       orop;
        logic       ovf;
        logic [2:0] src;
        logic [1:0] store;
        logic       save;
        logic       busy;
        logic       done;
        logic       ill;
        logic       ready;
    } ctrl_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_q, div_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              accept, is_md, early;

`ifdef ALU_SEQ_MD_EARLY_DONE_EN
    assign early = md_early;
`else
    assign early = 1'b0;
`endif

    assign op_ready = ctrl_q.ready;
    assign accept   = op_valid && op_ready && !flush;
    assign is_md    = (controlType == CTRL_W'(9)) || (controlType == CTRL_W'(10));
    assign {condType, divOp, multOp, ALUOp, orOp, overflowOp, SrcOut, StoreMD,
            ALUOutSave, busy, op_done, illegal_op} = ctrl_q[18:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= 1'b0;
            ctrl_q       <= '0;
            ctrl_q.ready <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        div_d   = div_q;
        if (!flush) begin
            case (state_q)
                IDLE, EXEC: if (accept) begin
                    state_d = is_md ? MD_RUN : EXEC;
                    cnt_d   = is_md ? CNT_W'(MD_CYCLES - 1) : '0;
                    div_d   = is_md ? (controlType == CTRL_W'(9)) : div_q;
                end
                MD_RUN: begin
                    state_d = (cnt_q == '0 || early) ? MD_WB : MD_RUN;
                    cnt_d   = (cnt_q == '0 || early) ? '0 : cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded for the state being entered so they appear registered.
    always_comb begin
        ctrl_d       = '0;
        ctrl_d.ready = (state_d == IDLE) || (state_d == EXEC);
        ctrl_d.busy  = state_d == MD_RUN;
        ctrl_d.div   = ctrl_d.busy && div_d;
        ctrl_d.mult  = ctrl_d.busy && !div_d;
        ctrl_d.store = (state_d == MD_WB) ? (div_d ? 2'b01 : 2'b10) : 2'b00;
        ctrl_d.done  = (state_d == EXEC) || (state_d == MD_WB);
        if (state_d == EXEC) begin
            case (controlType)
                CTRL_W'(0), CTRL_W'(3), CTRL_W'(5), CTRL_W'(6): begin
                    ctrl_d.alu = controlType[2:0]; ctrl_d.src = 3'b011; ctrl_d.save = 1'b1;
                end
                CTRL_W'(1), CTRL_W'(2), CTRL_W'(4): begin
                    ctrl_d.alu = controlType[2:0]; ctrl_d.src = 3'b011; ctrl_d.save = 1'b1;
                    ctrl_d.ovf = 1'b1;
                end
                CTRL_W'(7):  begin ctrl_d.alu = 3'b111; ctrl_d.src = 3'b010; ctrl_d.save = 1'b1; end
                CTRL_W'(8):  begin ctrl_d.orop = 1'b1; ctrl_d.src = 3'b100; ctrl_d.save = 1'b1; end
                CTRL_W'(11): begin ctrl_d.alu = 3'b001; ctrl_d.src = 3'b011; ctrl_d.save = 1'b1; end
                CTRL_W'(12): begin ctrl_d.src = 3'b001; ctrl_d.save = 1'b1; end
                CTRL_W'(13): begin ctrl_d.src = 3'b000; ctrl_d.save = 1'b1; end
                CTRL_W'(18): begin ctrl_d.src = 3'b110; ctrl_d.save = 1'b1; end
                CTRL_W'(14): ctrl_d.cond = 2'b00;
                CTRL_W'(15): ctrl_d.cond = 2'b01;
                CTRL_W'(16): ctrl_d.cond = 2'b10;
                CTRL_W'(17): ctrl_d.cond = 2'b11;
                default:     ctrl_d.ill  = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_control.sv
// tb_alu_seq_control: vector table, directed MULT/DIV/flush/reset sequences and a random run
// checked every cycle against a queue-based model of the expected output stream.
module tb_alu_seq_control;
    localparam int MDC = 32;

    typedef struct packed {
        logic [1:0] cond;
        logic       dv, ml;
        logic [2:0] alu;
        logic       orr, ovf;
        logic [2:0] src;
        logic [1:0] st;
        logic       sv, bz, dn, il, rd;
    } rec_t;

    typedef struct {
        logic [4:0] code;
        rec_t       exp;
    } vec_t;

    logic clk = 0, rst_n = 0, op_valid = 0, flush = 0, md_early = 0;
    logic op_ready, divOp, multOp, orOp, overflowOp, ALUOutSave, busy, op_done, illegal_op;
    logic [4:0] controlType = '0;
    logic [1:0] condType, StoreMD;
    logic [2:0] ALUOp, SrcOut;
    rec_t act;
    int errs = 0, checks = 0;

    localparam rec_t IDLE_R = 19'h1;

    alu_seq_control #(.CTRL_W(5), .MD_CYCLES(MDC)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .controlType(controlType), .flush(flush),
`ifdef ALU_SEQ_MD_EARLY_DONE_EN
        .md_early(md_early),
`endif
        .condType(condType), .divOp(divOp), .multOp(multOp), .ALUOp(ALUOp), .orOp(orOp),
        .overflowOp(overflowOp), .SrcOut(SrcOut), .StoreMD(StoreMD), .ALUOutSave(ALUOutSave),
        .busy(busy), .op_done(op_done), .illegal_op(illegal_op)
    );

    assign act = {condType, divOp, multOp, ALUOp, orOp, overflowOp, SrcOut, StoreMD,
                  ALUOutSave, busy, op_done, illegal_op, op_ready};

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t mk(int alu, int src, bit sv, bit ovf, bit orr, int cond, bit il);
        rec_t r = IDLE_R;
        r.alu = 3'(alu); r.src = 3'(src); r.sv = sv; r.ovf = ovf; r.orr = orr;
        r.cond = 2'(cond); r.il = il; r.dn = 1'b1;
        return r;
    endfunction

    // Single-cycle op results, written straight from the decode table.
    function automatic rec_t dec(int c);
        if (c <= 6)              return mk(c, 3, 1, c == 1 || c == 2 || c == 4, 0, 0, 0);
        if (c == 7)              return mk(7, 2, 1, 0, 0, 0, 0);
        if (c == 8)              return mk(0, 4, 1, 0, 1, 0, 0);
        if (c == 11)             return mk(1, 3, 1, 0, 0, 0, 0);
        if (c == 12)             return mk(0, 1, 1, 0, 0, 0, 0);
        if (c == 13)             return mk(0, 0, 1, 0, 0, 0, 0);
        if (c == 18)             return mk(0, 6, 1, 0, 0, 0, 0);
        if (c >= 14 && c <= 17)  return mk(0, 0, 0, 0, 0, c - 14, 0);
        return mk(0, 0, 0, 0, 0, 0, 1);
    endfunction

    // Model: the expected output stream; an accepted MULT/DIV schedules all its future cycles.
    initial begin
        rec_t cur, nxt, r, w;
        rec_t q[$];
        cur = IDLE_R;
        forever begin
            @(posedge clk);
            if (!rst_n || flush) begin
                q.delete(); nxt = IDLE_R;
            end else if (q.size() != 0) begin
                if (md_early && cur.bz) begin nxt = q[$]; q.delete(); end
                else nxt = q.pop_front();
            end else if (op_valid && cur.rd) begin
                if (controlType == 9 || controlType == 10) begin
                    r = '0; r.bz = 1; r.dv = controlType == 9; r.ml = controlType == 10;
                    w = '0; w.dn = 1; w.st = (controlType == 9) ? 2'b01 : 2'b10;
                    for (int i = 1; i < MDC; i++) q.push_back(r);
                    q.push_back(w);
                    nxt = r;
                end else nxt = dec(int'(controlType));
            end else nxt = IDLE_R;
            cur = nxt;
            #2;
            if (!rst_n) begin cur = IDLE_R; q.delete(); end
            chk("model", int'(act), int'(cur));
        end
    end

    initial begin
        vec_t tbl[14];
        int n;
        tbl = '{'{5'd0,  mk(0, 3, 1, 0, 0, 0, 0)}, '{5'd8,  mk(0, 4, 1, 0, 1, 0, 0)},
                '{5'd15, mk(0, 0, 0, 0, 0, 1, 0)}, '{5'd7,  mk(7, 2, 1, 0, 0, 0, 0)},
                '{5'd11, mk(1, 3, 1, 0, 0, 0, 0)}, '{5'd4,  mk(4, 3, 1, 1, 0, 0, 0)},
                '{5'd13, mk(0, 0, 1, 0, 0, 0, 0)}, '{5'd12, mk(0, 1, 1, 0, 0, 0, 0)},
                '{5'd18, mk(0, 6, 1, 0, 0, 0, 0)}, '{5'd17, mk(0, 0, 0, 0, 0, 3, 0)},
                '{5'd31, mk(0, 0, 0, 0, 0, 0, 1)}, '{5'd1,  mk(1, 3, 1, 1, 0, 0, 0)},
                '{5'd3,  mk(3, 3, 1, 0, 0, 0, 0)}, '{5'd19, mk(0, 0, 0, 0, 0, 0, 1)}};
        repeat (3) tick();
        chk("reset_state", int'(act), int'(IDLE_R));
        rst_n = 1;
        tick();
        op_valid = 1; controlType = 5'd2;
        tick();
        op_valid = 0;
        chk("sub_ovf", int'(act), int'(mk(2, 3, 1, 1, 0, 0, 0)));
        tick();
        chk("after_single", int'(act), int'(IDLE_R));
        for (int i = 0; i < 14; i++) begin
            op_valid = 1; controlType = tbl[i].code;
            tick();
            chk($sformatf("vec_%0d", tbl[i].code), int'(act), int'(tbl[i].exp));
        end
        op_valid = 0;
        tick();
        op_valid = 1; controlType = 5'd10;
        tick();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (act.st != 0) break;
            n += int'(act.ml && act.bz && !act.rd);
            op_valid = (i >= 5 && i < 10);
            controlType = 5'd0;
            tick();
        end
        op_valid = 0;
        chk("mult_cycles", n, MDC);
        chk("mult_wb", int'({act.st, act.dn}), 3'b101);
        tick();
        chk("mult_idle", int'(act), int'(IDLE_R));
        op_valid = 1; controlType = 5'd9;
        tick();
        op_valid = 0;
        repeat (9) tick();
        chk("div_running", int'(act.dv), 1);
        flush = 1;
        tick();
        flush = 0;
        chk("flush", int'(act), int'(IDLE_R));
        op_valid = 1; controlType = 5'd1;
        tick();
        op_valid = 0;
        chk("after_flush", int'(act), int'(mk(1, 3, 1, 1, 0, 0, 0)));
        op_valid = 1; controlType = 5'd9;
        tick();
        op_valid = 0;
        repeat (5) tick();
        rst_n = 0;
        #1;
        chk("rst_mid_div", int'(act), int'(IDLE_R));
        repeat (2) tick();
        rst_n = 1;
        tick();
`ifdef ALU_SEQ_MD_EARLY_DONE_EN
        op_valid = 1; controlType = 5'd9;
        tick();
        op_valid = 0;
        repeat (4) tick();
        md_early = 1;
        tick();
        md_early = 0;
        chk("early_wb", int'({act.st, act.dn, act.bz}), 4'b0110);
        tick();
`endif
        repeat (3000) begin
            op_valid    = 1'($urandom_range(0, 1));
            controlType = 5'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 40) == 0);
            rst_n       = ($urandom_range(0, 300) != 0);
`ifdef ALU_SEQ_MD_EARLY_DONE_EN
            md_early    = ($urandom_range(0, 20) == 0);
`endif
            tick();
        end
        op_valid = 0; flush = 0; rst_n = 1; md_early = 0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
